simd_alu_pipe: RTL and testbench
================================

SIMD_ALU_PIPE -- requirements
Module: simd_alu_pipe

Interface
REQ-001 Parameter W, default 64, meaning datapath width in bits; SHALL be a multiple of 32 and at least 32.
REQ-002 Parameter ACC_EN, default 1, meaning the per-32-bit-lane accumulator exists; when 0, OP_ACC32 and OP_CLRACC SHALL behave as OP_SEL0.
REQ-003 clk  input  1  the single clock; all state SHALL change only on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  the operand beat is valid.
REQ-006 in_ready  output  1  the block accepts a beat this cycle.
REQ-007 in_op  input  4  the opcode.
REQ-008 in_a, in_b  input  W  the operands, little-endian byte lanes.
REQ-009 out_valid  output  1  the result beat is valid.
REQ-010 out_ready  input  1  the consumer accepts the result.
REQ-011 out_y  output  W  the result.
REQ-012 out_c  output  W/8  the per-byte carry/saturation flags.

Function
REQ-013 Opcode encodings SHALL be: 0000 SEL0 (y=a), 0001 SEL1 (y=b), 0010 ADD32, 0011 SUB32, 0100 ADD16, 0101 SUB16, 0110 ADD8, 0111 SUB8, 1000 ADDSUB16, 1001 SUBADD16, 1010 ADDSUB8, 1011 SUBADD8, 1100 ADDS8, 1101 SUBS8, 1110 ACC32, 1111 CLRACC.
REQ-014 Element arithmetic SHALL be modulo 2^n per element; no carry SHALL cross an element boundary; subtraction SHALL be computed as a + ~b + 1.
REQ-015 ADDSUB ops SHALL add on odd-index elements and subtract on even-index elements; SUBADD ops SHALL do the reverse.
REQ-016 ADDS8 and SUBS8 SHALL use unsigned saturation per byte: a sum above 255 clamps to 255, and a difference below 0 clamps to 0.
REQ-017 out_c bit at the top byte of each element SHALL hold that element's carry-out (add) or carry-out of a + ~b + 1 (sub); every other bit SHALL be 0.
REQ-018 For saturating ops, out_c[i] SHALL be 1 exactly when byte i clamped.
REQ-019 For SEL0, SEL1 and CLRACC, out_c SHALL be all 0.
REQ-020 The pipeline SHALL have two register stages, S1 (operands and op) and S2 (result and flags).
REQ-021 Latency SHALL be exactly 2 cycles from acceptance to out_valid when unstalled.
REQ-022 Throughput SHALL be one beat per cycle.
REQ-023 The global advance signal SHALL be adv = !out_valid || out_ready.
REQ-024 in_ready SHALL equal adv; both stages SHALL load only when adv=1.
REQ-025 Bubbles SHALL propagate and need not be collapsed.
REQ-026 While out_valid=1 and out_ready=0, out_y, out_c and out_valid SHALL hold stable.
REQ-027 A beat SHALL be accepted only when in_valid && in_ready; in_op/in_a/in_b SHALL be ignored otherwise.
REQ-028 The accumulator SHALL be W bits, organised as W/32 independent 32-bit lanes.
REQ-029 ACC32 SHALL update each lane as acc = acc + a (mod 2^32) in the cycle the beat enters S2, and its result SHALL be the updated accumulator value.
REQ-030 CLRACC SHALL zero the accumulator when the beat enters S2, and its result SHALL be 0.
REQ-031 Back-to-back ACC32 beats SHALL see each preceding update, with no hazard bubble.
REQ-032 The accumulator SHALL change only when an ACC32 or CLRACC beat advances into S2; a stall SHALL NOT change it.
REQ-033 Undefined behaviour SHALL NOT exist: all 16 opcodes are defined.

Reset
REQ-034 While rst_n=0 at a clock edge, out_valid, the S1 valid bit and the accumulator SHALL clear to 0.
REQ-035 While rst_n=0 at a clock edge, out_y and out_c SHALL clear to 0.
REQ-036 in_ready SHALL be 1 on the first cycle after reset deasserts.
REQ-037 Reset mid-operation SHALL discard all in-flight beats without producing output.
REQ-038 Data-path registers other than out_y/out_c need not be reset.

Verification (W=64)
REQ-039 ADD8 a=0x00000000_FF0180FF, b=0x00000000_01FF8001 -> y=0x00000000_00000000, c=0x00_00_00_00_01_01_01_01 (byte-wise flags, LSB byte last), out_valid 2 cycles after acceptance.
REQ-040 ADDS8 a=0x...F0_10, b=0x...20_20 -> low bytes y=0xFF_30, c low bits=10b; SUBS8 with 0x05-0x09 -> 0x00, flag set.
REQ-041 ADDSUB16 a=0x0005_0005 (per 32-bit group), b=0x0003_0003 -> y=0x0008_0002.
REQ-042 CLRACC, then ACC32 a=1 three times back-to-back, then ACC32 a=0xFFFFFFFF -> results 0, 1, 2, 3, 2 in both lanes; the last beat has c set at bytes 3 and 7.
REQ-043 Hold out_ready=0 for 5 cycles with a stream of 4 beats -> in_ready=0 from the stalled cycle, out_y stable, no beat lost or duplicated, order preserved after release.
REQ-044 Assert rst_n=0 for 1 cycle with 2 beats in flight -> no out_valid afterwards, accumulator reads 0 on the next ACC32 with a=0.

Source files
------------

// File: rtl/simd_alu_pipe.sv
// simd_alu_pipe: two-stage packed-SIMD integer ALU (8/16/32-bit elements) with an
// optional per-32-bit-lane accumulator. S1 holds the accepted beat, S2 the result.
module simd_alu_pipe #(
    parameter int W      = 64,
    parameter int ACC_EN = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [3:0]     in_op,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_y,
    output logic [W/8-1:0] out_c
);

    localparam int NB = W / 8;

    localparam logic [3:0] OP_SEL0     = 4'b0000;
    localparam logic [3:0] OP_SEL1     = 4'b0001;
    localparam logic [3:0] OP_ADD32    = 4'b0010;
    localparam logic [3:0] OP_SUB32    = 4'b0011;
    localparam logic [3:0] OP_ADD16    = 4'b0100;
    localparam logic [3:0] OP_SUB16    = 4'b0101;
    localparam logic [3:0] OP_ADD8     = 4'b0110;
    localparam logic [3:0] OP_SUB8     = 4'b0111;
    localparam logic [3:0] OP_ADDSUB16 = 4'b1000;
    localparam logic [3:0] OP_SUBADD16 = 4'b1001;
    localparam logic [3:0] OP_ADDSUB8  = 4'b1010;
    localparam logic [3:0] OP_SUBADD8  = 4'b1011;
    localparam logic [3:0] OP_ADDS8    = 4'b1100;
    localparam logic [3:0] OP_SUBS8    = 4'b1101;
    localparam logic [3:0] OP_ACC32    = 4'b1110;
    localparam logic [3:0] OP_CLRACC   = 4'b1111;

    typedef enum logic [1:0] {M_ADD, M_SUB, M_ADDSUB, M_SUBADD} mode_e;
    typedef enum logic [1:0] {R_A, R_B, R_ZERO, R_ARITH} sel_e;

    logic          adv;

    logic          s1_valid_q;
    logic [3:0]    s1_op_q;
    logic [W-1:0]  s1_a_q;
    logic [W-1:0]  s1_b_q;

    logic          out_valid_q;
    logic [W-1:0]  y_q, y_d;
    logic [NB-1:0] c_q, c_d;
    logic [W-1:0]  acc_q, acc_d;

    int            esz_lg;
    mode_e         mode;
    sel_e          sel;
    logic          sat;
    logic          acc_upd;
    logic          acc_clr;
    logic [W-1:0]  opb;

    logic [NB-1:0] byte_sub;
    logic [NB-1:0] byte_first;
    logic [NB-1:0] byte_last;

    logic [W-1:0]  sum_y;
    logic [NB-1:0] sum_co;
    logic          chain;
    logic          cin;
    logic [7:0]    b_byte;
    logic [8:0]    s9;
    logic          clamp;

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_y     = y_q;
    assign out_c     = c_q;

    // Opcode decode: element size, add/sub pattern and result source.
    always_comb begin
        esz_lg  = 0;
        mode    = M_ADD;
        sel     = R_ARITH;
        sat     = 1'b0;
        acc_upd = 1'b0;
        acc_clr = 1'b0;
        opb     = s1_b_q;
        case (s1_op_q)
            OP_SEL0:     sel = R_A;
            OP_SEL1:     sel = R_B;
            OP_ADD32:    esz_lg = 2;
            OP_SUB32:    begin esz_lg = 2; mode = M_SUB; end
            OP_ADD16:    esz_lg = 1;
            OP_SUB16:    begin esz_lg = 1; mode = M_SUB; end
            OP_ADD8:     esz_lg = 0;
            OP_SUB8:     mode = M_SUB;
            OP_ADDSUB16: begin esz_lg = 1; mode = M_ADDSUB; end
            OP_SUBADD16: begin esz_lg = 1; mode = M_SUBADD; end
            OP_ADDSUB8:  mode = M_ADDSUB;
            OP_SUBADD8:  mode = M_SUBADD;
            OP_ADDS8:    sat = 1'b1;
            OP_SUBS8:    begin sat = 1'b1; mode = M_SUB; end
            OP_ACC32: begin
                if (ACC_EN != 0) begin
                    esz_lg  = 2;
                    opb     = acc_q;
                    acc_upd = 1'b1;
                end else begin
                    sel = R_A;
                end
            end
            OP_CLRACC: begin
                if (ACC_EN != 0) begin
                    sel     = R_ZERO;
                    acc_clr = 1'b1;
                end else begin
                    sel = R_A;
                end
            end
        endcase
    end

    always_comb begin
        byte_sub   = '0;
        byte_first = '0;
        byte_last  = '0;
        for (int i = 0; i < NB; i++) begin
            byte_first[i] = ((i & ((1 << esz_lg) - 1)) == 0);
            byte_last[i]  = ((i & ((1 << esz_lg) - 1)) == ((1 << esz_lg) - 1));
            case (mode)
                M_SUB:    byte_sub[i] = 1'b1;
                M_ADDSUB: byte_sub[i] = (((i >> esz_lg) & 1) == 0);
                M_SUBADD: byte_sub[i] = (((i >> esz_lg) & 1) == 1);
                default:  byte_sub[i] = 1'b0;
            endcase
        end
    end

    // Byte-sliced adder; the carry chain is broken at every element boundary,
    // where the carry-in becomes 1 for subtracting elements (a + ~b + 1).
    always_comb begin
        sum_y  = '0;
        sum_co = '0;
        chain  = 1'b0;
        cin    = 1'b0;
        b_byte = '0;
        s9     = '0;
        for (int i = 0; i < NB; i++) begin
            b_byte          = byte_sub[i] ? ~opb[8*i +: 8] : opb[8*i +: 8];
            cin             = byte_first[i] ? byte_sub[i] : chain;
            s9              = {1'b0, s1_a_q[8*i +: 8]} + {1'b0, b_byte} + {8'd0, cin};
            sum_y[8*i +: 8] = s9[7:0];
            sum_co[i]       = s9[8];
            chain           = s9[8];
        end
    end

    always_comb begin
        y_d   = sum_y;
        c_d   = sum_co & byte_last;
        clamp = 1'b0;
        case (sel)
            R_A: begin
                y_d = s1_a_q;
                c_d = '0;
            end
            R_B: begin
                y_d = s1_b_q;
                c_d = '0;
            end
            R_ZERO: begin
                y_d = '0;
                c_d = '0;
            end
            default: begin
                if (sat) begin
                    for (int i = 0; i < NB; i++) begin
                        // Unsigned: add overflows on carry, subtract underflows on no-carry.
                        clamp = byte_sub[i] ? !sum_co[i] : sum_co[i];
                        if (clamp) begin
                            y_d[8*i +: 8] = byte_sub[i] ? 8'h00 : 8'hFF;
                        end
                        c_d[i] = clamp;
                    end
                end
            end
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        if (acc_upd) begin
            acc_d = sum_y;
        end
        if (acc_clr) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            c_q         <= '0;
            acc_q       <= '0;
        end else if (adv) begin
            s1_valid_q  <= in_valid;
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                y_q   <= y_d;
                c_q   <= c_d;
                acc_q <= acc_d;
            end
        end
    end

    // Operand registers carry no reset; the S1 valid bit qualifies them.
    always_ff @(posedge clk) begin
        if (adv && in_valid) begin
            s1_op_q <= in_op;
            s1_a_q  <= in_a;
            s1_b_q  <= in_b;
        end
    end

endmodule

// File: tb/tb_simd_alu_pipe.sv
// Bench for simd_alu_pipe (W=64): directed literal cases plus randomized traffic
// checked every cycle against an element-arithmetic reference model.
module tb_simd_alu_pipe;

    localparam int W  = 64;
    localparam int NB = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_y;
    logic [NB-1:0] out_c;

    int total = 0;
    int bad   = 0;

    logic [63:0] exp_y[$];
    logic [7:0]  exp_c[$];
    logic [63:0] obs_y[$];
    logic [7:0]  obs_c[$];
    logic [63:0] acc_m;
    logic        stall_q;
    logic [63:0] prev_y;
    logic [7:0]  prev_c;

    simd_alu_pipe #(.W(W), .ACC_EN(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_c     (out_c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: each element treated as an unsigned number of its width.
    function automatic void model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                  input logic [63:0] acc, output logic [63:0] y,
                                  output logic [7:0] c, output logic [63:0] nacc);
        int eb;
        longint unsigned ea, ebv, md, r;
        bit sub, cy;
        y    = '0;
        c    = '0;
        nacc = acc;
        case (op)
            4'd0:  y = a;
            4'd1:  y = b;
            4'd15: begin y = '0; nacc = '0; end
            4'd14: begin
                for (int l = 0; l < 2; l++) begin
                    ea  = longint'(a[32*l +: 32]);
                    ebv = longint'(acc[32*l +: 32]);
                    r   = ea + ebv;
                    y[32*l +: 32] = r[31:0];
                    c[4*l+3] = (r >= 64'h1_0000_0000);
                end
                nacc = y;
            end
            default: begin
                eb = (op == 4'd2 || op == 4'd3) ? 4 :
                     (op == 4'd4 || op == 4'd5 || op == 4'd8 || op == 4'd9) ? 2 : 1;
                md = 64'd1 << (8 * eb);
                for (int e = 0; e < 8 / eb; e++) begin
                    ea  = (a >> (8 * eb * e)) & (md - 1);
                    ebv = (b >> (8 * eb * e)) & (md - 1);
                    case (op)
                        4'd3, 4'd5, 4'd7, 4'd13: sub = 1'b1;
                        4'd8, 4'd10:             sub = (e % 2 == 0);
                        4'd9, 4'd11:             sub = (e % 2 == 1);
                        default:                 sub = 1'b0;
                    endcase
                    if (sub) begin
                        cy = (ea >= ebv);
                        r  = (ea + md - ebv) % md;
                    end else begin
                        r  = ea + ebv;
                        cy = (r >= md);
                        r  = r % md;
                    end
                    if (op == 4'd12) begin
                        if (cy) r = 255;
                        c[e] = cy;
                    end else if (op == 4'd13) begin
                        if (!cy) r = 0;
                        c[e] = !cy;
                    end else begin
                        c[e*eb + eb - 1] = cy;
                    end
                    y = y | (r << (8 * eb * e));
                end
            end
        endcase
    endfunction

    // Per-cycle checker, sampled on the falling edge while inputs and outputs are stable.
    always @(negedge clk) begin
        logic [63:0] my, na;
        logic [7:0]  mc;
        if (!rst_n) begin
            exp_y.delete();
            exp_c.delete();
            acc_m   = '0;
            stall_q = 1'b0;
        end else begin
            chk("in_ready_rule", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
            if (stall_q) begin
                chk("hold_valid", {63'd0, out_valid}, 64'd1);
                chk("hold_y", out_y, prev_y);
                chk("hold_c", {56'd0, out_c}, {56'd0, prev_c});
            end
            if (exp_y.size() == 0) begin
                chk("spurious_out_valid", {63'd0, out_valid}, 64'd0);
            end else if (out_valid && out_ready) begin
                chk("out_y", out_y, exp_y[0]);
                chk("out_c", {56'd0, out_c}, {56'd0, exp_c[0]});
                void'(exp_y.pop_front());
                void'(exp_c.pop_front());
                obs_y.push_back(out_y);
                obs_c.push_back(out_c);
            end
            if (in_valid && in_ready) begin
                model(in_op, in_a, in_b, acc_m, my, mc, na);
                exp_y.push_back(my);
                exp_c.push_back(mc);
                acc_m = na;
            end
            stall_q = out_valid && !out_ready;
            prev_y  = out_y;
            prev_c  = out_c;
        end
    end

    task automatic send(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        int k;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) chk("accept_timeout", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = {$urandom, $urandom};
        in_b     = {$urandom, $urandom};
    endtask

    task automatic wait_obs(input int n);
        int k;
        k = 0;
        while (obs_y.size() < n && k < 60) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (obs_y.size() < n) chk("obs_count", 64'(obs_y.size()), 64'(n));
    endtask

    task automatic pop_chk(input string name, input logic [63:0] y, input logic [7:0] c);
        if (obs_y.size() == 0) begin
            chk({name, "_missing"}, 64'd0, 64'd1);
        end else begin
            chk({name, "_y"}, obs_y.pop_front(), y);
            chk({name, "_c"}, {56'd0, obs_c.pop_front()}, {56'd0, c});
        end
    endtask

    function automatic logic [63:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0:       return 64'hFFFF_FFFF_FFFF_FFFF;
            1:       return 64'd0;
            2:       return 64'h8080_8080_8080_8080;
            3:       return {32'd0, $urandom} & 64'h00FF_00FF_00FF_00FF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] my, na;
        logic [7:0]  mc;
        int k;

        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;

        // Pin the model itself with hand-computed values.
        model(4'd6, 64'h00000000_FF0180FF, 64'h00000000_01FF8001, 64'd0, my, mc, na);
        chk("pin_add8_y", my, 64'd0);
        chk("pin_add8_c", {56'd0, mc}, 64'h0F);
        model(4'd12, 64'hF010, 64'h2020, 64'd0, my, mc, na);
        chk("pin_adds8_y", my, 64'hFF30);
        chk("pin_adds8_c", {56'd0, mc}, 64'h02);
        model(4'd8, 64'h0005_0005_0005_0005, 64'h0003_0003_0003_0003, 64'd0, my, mc, na);
        chk("pin_addsub16_y", my, 64'h0008_0002_0008_0002);
        model(4'd14, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'h0000_0003_0000_0003, my, mc, na);
        chk("pin_acc_y", my, 64'h0000_0002_0000_0002);
        chk("pin_acc_c", {56'd0, mc}, 64'h88);

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_y", out_y, 64'd0);
        chk("rst_out_c", {56'd0, out_c}, 64'd0);
        @(posedge clk);
        #1;

        obs_y.delete(); obs_c.delete();
        send(4'd6, 64'h00000000_FF0180FF, 64'h00000000_01FF8001);
        @(negedge clk);
        chk("latency_c1_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        chk("latency_c2_valid", {63'd0, out_valid}, 64'd1);
        @(posedge clk);
        #1;
        wait_obs(1);
        pop_chk("add8", 64'd0, 8'h0F);

        send(4'd12, 64'hF010, 64'h2020);
        send(4'd13, 64'h05, 64'h09);
        wait_obs(2);
        pop_chk("adds8", 64'hFF30, 8'h02);
        pop_chk("subs8", 64'h00, 8'h01);

        send(4'd8, 64'h0005_0005_0005_0005, 64'h0003_0003_0003_0003);
        wait_obs(1);
        pop_chk("addsub16", 64'h0008_0002_0008_0002, 8'h22);

        send(4'd15, 64'h1234_5678_9ABC_DEF0, 64'd7);
        repeat (3) send(4'd14, 64'h0000_0001_0000_0001, 64'd0);
        send(4'd14, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        wait_obs(5);
        pop_chk("clracc", 64'd0, 8'h00);
        pop_chk("acc1", 64'h0000_0001_0000_0001, 8'h00);
        pop_chk("acc2", 64'h0000_0002_0000_0002, 8'h00);
        pop_chk("acc3", 64'h0000_0003_0000_0003, 8'h00);
        pop_chk("acc_wrap", 64'h0000_0002_0000_0002, 8'h88);

        out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 4; i++) send(4'd1, 64'hAAAA, 64'(i));
            end
            begin
                repeat (5) @(posedge clk);
                @(negedge clk);
                chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_obs(4);
        for (int i = 1; i <= 4; i++) pop_chk("stall_order", 64'(i), 8'h00);

        out_ready = 1'b0;
        send(4'd14, 64'h0000_0005_0000_0005, 64'd0);
        send(4'd14, 64'h0000_0007_0000_0007, 64'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        obs_y.delete(); obs_c.delete();
        @(negedge clk);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (3) begin
            chk("midrst_no_valid", {63'd0, out_valid}, 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        send(4'd14, 64'd0, 64'd0);
        wait_obs(1);
        pop_chk("midrst_acc", 64'd0, 8'h00);

        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op     = 4'($urandom_range(0, 15));
            in_a      = rnd_opnd();
            in_b      = rnd_opnd();
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n     = (n != 1500);
            @(posedge clk);
            #1;
        end
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while (exp_y.size() != 0 && k < 20) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("drain_empty", 64'(exp_y.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
